reg_bus_master: RTL and testbench

Initiator for the 24-bit-address / 32-bit-data register bus (address strobe `as`, active-low read/write strobes, 4-bit size code on `be`). It accepts single read/write commands on a valid/ready interface and sequences the bus strobes with fixed, registered timing. It returns read data or write completion on a one-cycle response pulse, and keeps issued-transaction counters for cross-checking against a target's count status word. It sits between a local command source (CPU bridge or test sequencer) and register-file targets.

---
 rtl/reg_bus_pkg.sv | 55 +++++
 rtl/reg_bus_txn_counter.sv | 21 ++
 rtl/reg_bus_master.sv | 160 ++++++++++++++++
 tb/tb_reg_bus_master.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the register bus initiator.
// State encoding, size codes, byte-enable codes and helpers.
package reg_bus_pkg;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_ERR
   } state_t;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   localparam logic [3:0] BE_WORD = 4'h0;
   localparam logic [3:0] BE_HALF = 4'h3;
   localparam logic [3:0] BE_BYTE = 4'h7;
   localparam logic [3:0] BE_IDLE = 4'hF;

   function automatic logic [3:0] be_of(
      input logic       write,
      input logic [1:0] size
   );
      logic [3:0] be;
      be = BE_IDLE;
      if (write) begin
         case (size)
            SZ_WORD: be = BE_WORD;
            SZ_HALF: be = BE_HALF;
            SZ_BYTE: be = BE_BYTE;
            default: be = BE_IDLE;
         endcase
      end
      return be;
   endfunction

   function automatic logic [DATA_W-1:0] mask_data(
      input logic [DATA_W-1:0] data,
      input logic [1:0]        size
   );
      logic [DATA_W-1:0] m;
      case (size)
         SZ_HALF: m = {16'h0000, data[15:0]};
         SZ_BYTE: m = {24'h000000, data[7:0]};
         default: m = data;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/reg_bus_txn_counter.sv
// 16-bit wrapping transaction counter.
// Async active-low clear, single increment enable.
import reg_bus_pkg::*;

module reg_bus_txn_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [15:0] count
);

   // Count enabled increments; wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= 16'h0000;
      end else if (inc) begin
         count <= count + 16'h0001;
      end
   end

endmodule

// File: rtl/reg_bus_master.sv
// Register bus initiator: single commands in, strobed bus cycles out.
// All bus and response outputs are registered.
import reg_bus_pkg::*;

module reg_bus_master #(
   parameter int unsigned STROBE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [1:0]        cmd_size,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_dout,
   input  logic [DATA_W-1:0] bus_din,
   output logic              bus_as,
   output logic              bus_ws_n,
   output logic              bus_rs_n,
   output logic [3:0]        bus_be,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);

   localparam logic [3:0] SC_LAST = 4'(STROBE_CYCLES - 1);

   state_t            state, nxt;
   logic              is_wr, wr_d;
   logic [3:0]        cnt, cnt_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] dout_d, rdata_d;
   logic              as_d, ws_d, rs_d;
   logic [3:0]        be_d;
   logic              rv_d, re_d;
   logic              rd_inc, wr_inc;

   assign cmd_ready = (state == ST_IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= nxt;
      end
   end

   // Next state and next values of every registered output.
   always_comb begin
      nxt     = state;
      wr_d    = is_wr;
      cnt_d   = cnt;
      addr_d  = bus_addr;
      dout_d  = bus_dout;
      as_d    = bus_as;
      ws_d    = bus_ws_n;
      rs_d    = bus_rs_n;
      be_d    = bus_be;
      rv_d    = 1'b0;
      re_d    = 1'b0;
      rdata_d = '0;
      rd_inc  = 1'b0;
      wr_inc  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_size == 2'b11) begin
                  nxt = ST_ERR;
               end else begin
                  nxt    = ST_SETUP;
                  wr_d   = cmd_write;
                  addr_d = cmd_addr;
                  as_d   = 1'b1;
                  be_d   = be_of(cmd_write, cmd_size);
                  dout_d = cmd_write ? mask_data(cmd_wdata, cmd_size) : '0;
               end
            end
         end
         ST_SETUP: begin
            nxt   = ST_STROBE;
            ws_d  = ~is_wr;
            rs_d  = is_wr;
            cnt_d = SC_LAST;
         end
         ST_STROBE: begin
            if (cnt == 4'd0) begin
               nxt  = ST_HOLD;
               ws_d = 1'b1;
               rs_d = 1'b1;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end
         ST_HOLD: begin
            nxt     = ST_IDLE;
            as_d    = 1'b0;
            be_d    = BE_IDLE;
            rv_d    = 1'b1;
            rdata_d = is_wr ? '0 : bus_din;
            rd_inc  = ~is_wr;
            wr_inc  = is_wr;
         end
         ST_ERR: begin
            nxt  = ST_IDLE;
            rv_d = 1'b1;
            re_d = 1'b1;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   // Registered bus, response and sequencing state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         is_wr     <= 1'b0;
         cnt       <= 4'd0;
         bus_addr  <= '0;
         bus_dout  <= '0;
         bus_as    <= 1'b0;
         bus_ws_n  <= 1'b1;
         bus_rs_n  <= 1'b1;
         bus_be    <= BE_IDLE;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         is_wr     <= wr_d;
         cnt       <= cnt_d;
         bus_addr  <= addr_d;
         bus_dout  <= dout_d;
         bus_as    <= as_d;
         bus_ws_n  <= ws_d;
         bus_rs_n  <= rs_d;
         bus_be    <= be_d;
         rsp_valid <= rv_d;
         rsp_err   <= re_d;
         rsp_rdata <= rdata_d;
      end
   end

   reg_bus_txn_counter u_rd_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (rd_inc),
      .count (rd_count)
   );

   reg_bus_txn_counter u_wr_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (wr_inc),
      .count (wr_count)
   );

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master.
// Two instances: default strobe width and a 3-cycle strobe.
module tb_reg_bus_master;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_write = 1'b0;
   logic [1:0]  cmd_size = 2'b00;
   logic [23:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [31:0] bus_din = '0;
   logic [31:0] tgt_data = '0;

   logic        cmd_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata, bus_dout;
   logic [23:0] bus_addr;
   logic        bus_as, bus_ws_n, bus_rs_n;
   logic [3:0]  bus_be;
   logic [15:0] rd_count, wr_count;

   logic        valid3 = 1'b0;
   logic        ready3, rv3, re3;
   logic [31:0] rdata3, dout3;
   logic [23:0] addr3;
   logic        as3, ws3, rs3;
   logic [3:0]  be3;
   logic [15:0] rdc3, wrc3;

   int tests = 0;
   int fails = 0;
   int ws3_low = 0;
   int acc = 0;
   int acc_cyc [4];
   int rv_seen;

   always #5 clk = ~clk;

   reg_bus_master dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_size(cmd_size),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
      .bus_as(bus_as), .bus_ws_n(bus_ws_n), .bus_rs_n(bus_rs_n),
      .bus_be(bus_be), .rd_count(rd_count), .wr_count(wr_count)
   );

   reg_bus_master #(.STROBE_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst),
      .cmd_valid(valid3), .cmd_ready(ready3),
      .cmd_write(cmd_write), .cmd_size(cmd_size),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rv3), .rsp_err(re3), .rsp_rdata(rdata3),
      .bus_addr(addr3), .bus_dout(dout3), .bus_din(bus_din),
      .bus_as(as3), .bus_ws_n(ws3), .bus_rs_n(rs3),
      .bus_be(be3), .rd_count(rdc3), .wr_count(wrc3)
   );

   // Target model: captures read data on the edge it sees the strobe low.
   always @(posedge clk) begin
      if (!bus_rs_n) bus_din <= tgt_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Strobe protocol: never low outside bus_as, never both low.
   always @(negedge clk) begin
      if (rst) begin
         chk("proto", {31'd0, ((!bus_ws_n || !bus_rs_n) && !bus_as) ||
                              (!bus_ws_n && !bus_rs_n)}, 32'd0);
         chk("proto3", {31'd0, ((!ws3 || !rs3) && !as3) ||
                               (!ws3 && !rs3)}, 32'd0);
         if (!ws3) ws3_low++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset values while reset held.
      #12;
      chk("rst_ready", cmd_ready, 1);
      chk("rst_as", bus_as, 0);
      chk("rst_ws", bus_ws_n, 1);
      chk("rst_rs", bus_rs_n, 1);
      chk("rst_be", bus_be, 32'hF);
      chk("rst_addr", bus_addr, 0);
      chk("rst_dout", bus_dout, 0);
      chk("rst_rv", rsp_valid, 0);
      chk("rst_err", rsp_err, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_cnt", {rd_count, wr_count}, 0);
      rst = 1'b1;
      step();

      // Word write.
      cmd_valid = 1; cmd_write = 1; cmd_size = 2'b00;
      cmd_addr = 24'h000004; cmd_wdata = 32'hDEADBEEF;
      step();
      cmd_valid = 0; cmd_addr = 24'h00FFFF; cmd_wdata = 32'h0;
      chk("w_setup_as", bus_as, 1);
      chk("w_setup_ws", bus_ws_n, 1);
      chk("w_be", bus_be, 0);
      chk("w_dout", bus_dout, 32'hDEADBEEF);
      chk("w_ready", cmd_ready, 0);
      step();
      chk("w_strobe_ws", bus_ws_n, 0);
      chk("w_addr_stable", bus_addr, 24'h000004);
      step();
      chk("w_hold_ws", bus_ws_n, 1);
      chk("w_hold_as", bus_as, 1);
      chk("w_hold_rv", rsp_valid, 0);
      step();
      chk("w_rv", rsp_valid, 1);
      chk("w_err", rsp_err, 0);
      chk("w_rdata", rsp_rdata, 0);
      chk("w_as_drop", bus_as, 0);
      chk("w_be_idle", bus_be, 32'hF);
      chk("w_cnt", wr_count, 1);

      // Word read.
      tgt_data = 32'h12345678;
      cmd_valid = 1; cmd_write = 0; cmd_addr = 24'h000008;
      step();
      cmd_valid = 0;
      chk("r_be", bus_be, 32'hF);
      chk("r_dout", bus_dout, 0);
      chk("r_addr", bus_addr, 24'h000008);
      step();
      chk("r_strobe_rs", bus_rs_n, 0);
      chk("r_strobe_ws", bus_ws_n, 1);
      step();
      chk("r_hold_rs", bus_rs_n, 1);
      step();
      chk("r_rv", rsp_valid, 1);
      chk("r_rdata", rsp_rdata, 32'h12345678);
      chk("r_cnt", {rd_count, wr_count}, {16'd1, 16'd1});

      // Halfword write.
      cmd_valid = 1; cmd_write = 1; cmd_size = 2'b01;
      cmd_wdata = 32'hAAAA5555;
      step();
      cmd_valid = 0;
      chk("h_dout", bus_dout, 32'h00005555);
      chk("h_be", bus_be, 32'h3);
      step(); step(); step();
      chk("h_rv", rsp_valid, 1);
      chk("h_cnt", wr_count, 2);

      // Byte write.
      cmd_valid = 1; cmd_size = 2'b10;
      step();
      cmd_valid = 0;
      chk("b_dout", bus_dout, 32'h00000055);
      chk("b_be", bus_be, 32'h7);
      step(); step(); step();
      chk("b_rv", rsp_valid, 1);
      chk("b_cnt", wr_count, 3);

      // Illegal size.
      cmd_valid = 1; cmd_size = 2'b11;
      step();
      cmd_valid = 0;
      chk("e_as", bus_as, 0);
      chk("e_rv0", rsp_valid, 0);
      step();
      chk("e_rv", rsp_valid, 1);
      chk("e_err", rsp_err, 1);
      chk("e_rdata", rsp_rdata, 0);
      chk("e_as2", bus_as, 0);
      chk("e_cnt", {rd_count, wr_count}, {16'd1, 16'd3});
      step();
      chk("e_rv_off", rsp_valid, 0);

      // Back-to-back writes on the 3-cycle-strobe instance.
      cmd_size = 2'b00; cmd_write = 1; cmd_wdata = 32'h0BADF00D;
      ws3_low = 0;
      valid3 = 1;
      for (int c = 0; c < 40 && acc < 4; c++) begin
         @(negedge clk);
         if (ready3) begin
            acc_cyc[acc] = c;
            acc++;
         end
      end
      step();
      valid3 = 0;
      chk("bb_accepts", acc, 4);
      for (int i = 1; i < 4; i++)
         chk("bb_interval", acc_cyc[i] - acc_cyc[i-1], 6);
      repeat (8) step();
      chk("bb_cnt", wrc3, 4);
      chk("bb_ws_low", ws3_low, 12);

      // Reset during strobe.
      cmd_write = 0; cmd_addr = 24'h000010;
      cmd_valid = 1;
      step();
      cmd_valid = 0;
      step();
      chk("x_rs_low", bus_rs_n, 0);
      #2 rst = 0;
      #1;
      chk("x_rs", bus_rs_n, 1);
      chk("x_as", bus_as, 0);
      chk("x_cnt", {rd_count, wr_count}, 0);
      chk("x_ready", cmd_ready, 1);
      rv_seen = 0;
      repeat (2) begin
         step();
         if (rsp_valid) rv_seen++;
      end
      #2 rst = 1;
      repeat (3) begin
         step();
         if (rsp_valid) rv_seen++;
      end
      chk("x_no_rsp", rv_seen, 0);

      // Read after reset release.
      tgt_data = 32'hCAFEF00D;
      cmd_valid = 1;
      step();
      cmd_valid = 0;
      step(); step(); step();
      chk("xr_rv", rsp_valid, 1);
      chk("xr_rdata", rsp_rdata, 32'hCAFEF00D);
      chk("xr_cnt", {rd_count, wr_count}, {16'd1, 16'd0});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
